// File: rtl/mem_init_pkg.sv
// Shared types and sizing constants for the memory burst initiator.
package mem_init_pkg;

   localparam int AW_DEF = 3;
   localparam int DW_DEF = 8;
   localparam int LEN_W  = 3;

   typedef enum logic [2:0] {
      IDLE,
      WR_DATA,
      WR_CHECK,
      WR_RESP,
      RD_STROBE,
      RD_CAPTURE,
      RD_RESP
   } state_t;

endpackage

// File: rtl/mem_init_burst_ctr.sv
// Burst address and remaining-beat tracker; the address wraps at 2^AW.
module mem_init_burst_ctr
   import mem_init_pkg::*;
#(
   parameter int AW = AW_DEF
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [AW-1:0]    start_addr,
   input  logic [LEN_W-1:0] start_len,
   input  logic             step,
   output logic [AW-1:0]    addr,
   output logic             last
);

   logic [LEN_W-1:0] remaining;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr      <= '0;
         remaining <= '0;
      end else if (load) begin
         addr      <= start_addr;
         remaining <= start_len;
      end else if (step) begin
         addr      <= addr + 1'b1;
         remaining <= remaining - 1'b1;
      end
   end

   assign last = (remaining == '0);

endmodule

// File: rtl/mem_initiator.sv
// Host-to-memory burst initiator: turns read/write burst commands into
// single-cycle memory strobes and returns one response per read beat or per write burst.
module mem_initiator
   import mem_init_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [AW-1:0]    cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             wdata_valid,
   input  logic [DW-1:0]    wdata,
   output logic             wdata_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DW-1:0]    rsp_data,
   output logic             rsp_err,
   output logic             rsp_last,
   output logic             busy,
   output logic [DW-1:0]    mem_din,
   output logic [AW-1:0]    mem_addr,
   output logic             mem_wr,
   output logic             mem_rd,
   input  logic [DW-1:0]    mem_dout,
   input  logic             mem_error
);

   state_t        state;
   logic [AW-1:0] cur_addr;
   logic          last_beat;
   logic          ctr_load;
   logic          ctr_step;
   logic          err_flag;
   logic          wr_prev;

   assign cmd_ready   = (state == IDLE);
   assign wdata_ready = (state == WR_DATA);
   assign busy        = (state != IDLE);

   assign ctr_load = cmd_valid && (state == IDLE);
   assign ctr_step = !last_beat &&
                     (((state == WR_DATA) && wdata_valid) ||
                      ((state == RD_RESP) && rsp_ready));

   mem_init_burst_ctr #(.AW(AW)) u_ctr (
      .clk        (clk),
      .reset      (reset),
      .load       (ctr_load),
      .start_addr (cmd_addr),
      .start_len  (cmd_len),
      .step       (ctr_step),
      .addr       (cur_addr),
      .last       (last_beat)
   );

   // mem_error belongs to the strobe of the previous cycle, so wr_prev marks
   // when it must be folded into the sticky write error. The last write's error
   // arrives during the first WR_RESP cycle, hence the response is built one
   // cycle into WR_RESP; likewise RD_CAPTURE spends one cycle on the strobe itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         rsp_last  <= 1'b0;
         mem_din   <= '0;
         mem_addr  <= '0;
         mem_wr    <= 1'b0;
         mem_rd    <= 1'b0;
         err_flag  <= 1'b0;
         wr_prev   <= 1'b0;
      end else begin
         wr_prev <= mem_wr;
         if (wr_prev && mem_error) begin
            err_flag <= 1'b1;
         end
         case (state)
            IDLE: begin
               mem_wr <= 1'b0;
               mem_rd <= 1'b0;
               if (cmd_valid) begin
                  err_flag <= 1'b0;
                  state    <= cmd_write ? WR_DATA : RD_STROBE;
               end
            end
            WR_DATA: begin
               mem_wr <= wdata_valid;
               if (wdata_valid) begin
                  mem_din  <= wdata;
                  mem_addr <= cur_addr;
                  if (last_beat) begin
                     state <= WR_CHECK;
                  end
               end
            end
            WR_CHECK: begin
               mem_wr <= 1'b0;
               state  <= WR_RESP;
            end
            WR_RESP: begin
               if (!rsp_valid) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= '0;
                  rsp_last  <= 1'b1;
                  rsp_err   <= err_flag | (wr_prev & mem_error);
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            RD_STROBE: begin
               mem_rd   <= 1'b1;
               mem_addr <= cur_addr;
               state    <= RD_CAPTURE;
            end
            RD_CAPTURE: begin
               mem_rd <= 1'b0;
               if (!mem_rd) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= mem_dout;
                  rsp_err   <= mem_error;
                  rsp_last  <= last_beat;
                  state     <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= last_beat ? IDLE : RD_STROBE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- AW, 3, memory address width.
- DW, 8, memory data width.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  host command accepted when valid&&ready.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  AW  burst start address.
- cmd_len  in  3  burst beats minus one (0..7).
- wdata_valid  in  1  write beat valid.
- wdata  in  DW  write beat data.
- wdata_ready  out  1  write beat accepted when valid&&ready.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  DW  read data; 0 for write responses.
- rsp_err  out  1  memory reported error for this response.
- rsp_last  out  1  final response of burst.
- busy  out  1  high whenever state is not IDLE.
- mem_din  out  DW  memory write data.
- mem_addr  out  AW  memory address.
- mem_wr  out  1  memory write strobe.
- mem_rd  out  1  memory read strobe.
- mem_dout  in  DW  memory read data, valid the cycle after the mem_rd cycle.
- mem_error  in  1  memory error flag, valid the cycle after any strobe cycle.

Function
REQ-003 All outputs SHALL be registered except cmd_ready, wdata_ready and busy, which SHALL decode state only.
REQ-004 The FSM states SHALL be IDLE, WR_DATA, WR_CHECK, WR_RESP, RD_STROBE, RD_CAPTURE and RD_RESP.
REQ-005 cmd_ready SHALL be 1 only in IDLE; on acceptance the block SHALL latch addr, len and write, and go to WR_DATA (write) or RD_STROBE (read).
REQ-006 mem_wr and mem_rd SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per beat.
REQ-007 In WR_DATA, wdata_ready SHALL be 1; each handshake SHALL drive mem_wr=1, mem_din=wdata and mem_addr=current address in the next cycle; writes SHALL sustain one beat per cycle.
REQ-008 After the last write handshake, the FSM SHALL go to WR_CHECK for one cycle, then WR_RESP.
REQ-009 The write error flag SHALL be the sticky OR of mem_error over every cycle that follows a mem_wr cycle of the burst.
REQ-010 WR_RESP SHALL present one response (rsp_data=0, rsp_last=1, rsp_err=sticky flag) and hold it until rsp_ready, then go to IDLE.
REQ-011 A read beat SHALL proceed as follows:
- RD_STROBE drives mem_rd=1 for one cycle.
- RD_CAPTURE registers mem_dout and mem_error.
- RD_RESP holds rsp_valid with that data until rsp_ready.
REQ-012 First-read latency SHALL be 3 cycles: rsp_valid rises 3 edges after the cmd acceptance edge.
REQ-013 After a read handshake, the FSM SHALL go to RD_STROBE for the next beat, or to IDLE after the last beat; rsp_last SHALL be 1 only on the last beat.
REQ-014 The beat address SHALL increment by 1 modulo 2^AW, so 7 wraps to 0.
REQ-015 The beat count SHALL be cmd_len+1, giving 1 to 8 beats.
REQ-016 When rsp_valid=1 and rsp_ready=0, rsp_data, rsp_err and rsp_last SHALL stay stable and no new strobe SHALL issue.
REQ-017 When the FSM is idle, mem_wr and mem_rd SHALL be 0, and mem_din and mem_addr SHALL hold their last values.

Reset
REQ-018 While reset=1, the FSM SHALL be IDLE and every registered output (rsp_*, mem_din, mem_addr, mem_wr, mem_rd) SHALL be 0.
REQ-019 Reset asserted mid-burst SHALL abort the burst immediately, with no partial response and no further strobes.
REQ-020 cmd_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-021 A shared package mem_init_pkg SHALL hold the state enum, the AW/DW defaults and the length width constant.
REQ-022 Address increment, wrap and remaining-beat counting SHALL live in one sub-module, mem_init_burst_ctr.

Verification
REQ-023 The bench SHALL pair the block with the 8x8 register memory and cover the following scenarios:
- Write addr=6, len=3, data A1,A2,A3,A4 -> mem_wr on 4 consecutive cycles at addresses 6,7,0,1; one rsp with rsp_last=1, rsp_err=0.
- Read addr=6, len=3 -> rsp_data A1,A2,A3,A4; rsp_last only on the 4th beat; first rsp_valid 3 cycles after acceptance.
- Read of never-written addr=3, len=0 -> rsp_data=00, rsp_err=0, rsp_last=1.
- rsp_ready held 0 for 5 cycles during a read burst -> rsp fields stable; mem_rd stays 0 until the handshake.
- mem_error forced 1 after the 2nd write beat -> single write rsp with rsp_err=1.
- reset pulsed during the 3rd read beat -> all outputs 0; busy=0; cmd_ready=1 in the first cycle after reset deasserts.
